fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that lets several producers share one synchronous FIFO write port. It grants one requester at a time for a bounded burst and forwards that requester's data to the FIFO. It stalls on FIFO full without losing or duplicating beats. It sits directly in front of the team's 8-deep, 8-bit synchronous FIFO and drives its write-enable and data-in.

---
 rtl/fifo_wr_arbiter_if.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter_if
//  Description : Requester-side and FIFO-side signals of the write arbiter.
//  Revision    : 1.0
// ============================================================================
interface fifo_wr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               fifo_full;
   logic               fifo_write_e;
   logic [DW-1:0]      fifo_data_in;
   logic               grant_active;
   logic [IDW-1:0]     grant_id;

   modport master (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_write_e, fifo_data_in, grant_active, grant_id
   );

   modport slave (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_write_e, fifo_data_in, grant_active, grant_id
   );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin burst arbiter sharing one FIFO write port.
//  Revision    : 1.0
// ============================================================================
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   fifo_wr_arbiter_if.master bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW  = $clog2(MAX_BURST + 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic [IDW-1:0] last_q,  last_d;
   logic [BW-1:0]  beat_q,  beat_d;

   logic [DW-1:0]   lane [NREQ];
   logic [31:0]     cand;
   logic            pick_found;
   logic [IDW-1:0]  pick_idx;
   logic            in_grant;
   logic            owner_valid;
   logic            xfer;
   logic            burst_done;
   logic [NREQ-1:0] ready;

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign lane[g] = bus.req_data[g*DW +: DW];
   end

   // Descending scan so the smallest offset from last+1 is the one that sticks.
   always_comb begin : arbitration
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = int'(last_q) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (bus.req_valid[cand[IDW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IDW-1:0];
         end
      end
   end

   // Reset gates the handshake so a beat presented during reset is never taken.
   always_comb begin : datapath
      in_grant    = (state_q == S_GRANT);
      owner_valid = bus.req_valid[owner_q];
      xfer        = in_grant && !reset && owner_valid && !bus.fifo_full;
      burst_done  = (beat_q == BW'(MAX_BURST - 1));
      ready       = '0;
      if (in_grant && !reset && !bus.fifo_full) begin
         ready[owner_q] = 1'b1;
      end
   end

   assign bus.req_ready    = ready;
   assign bus.fifo_write_e = xfer;
   assign bus.fifo_data_in = in_grant ? lane[owner_q] : '0;
   assign bus.grant_active = in_grant;
   assign bus.grant_id     = owner_q;

   always_comb begin : next_state
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      beat_d  = beat_q;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               state_d = S_GRANT;
               owner_d = pick_idx;
               beat_d  = '0;
            end
         end
         S_GRANT: begin
            if (!owner_valid) begin
               state_d = S_IDLE;
               last_d  = owner_q;
            end else if (xfer) begin
               beat_d = beat_q + 1'b1;
               if (burst_done) begin
                  state_d = S_IDLE;
                  last_d  = owner_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         last_q  <= IDW'(NREQ - 1);
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed and random checks of fifo_wr_arbiter against a model.
//  Revision    : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;
   localparam int NREQ      = 4;
   localparam int DW        = 8;
   localparam int MAX_BURST = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int m_grant, m_owner, m_cnt, m_last;
   int waitg [NREQ];
   int acc_mask;
   int model_acc;
   int wr_cyc[$], wr_dat[$], wr_id[$], glog[$];
   logic [DW-1:0]   dat     [NREQ];
   logic [DW-1:0]   sb_next [NREQ];
   logic [NREQ-1:0] vld, vld_prev;
   logic            full;
   logic            prev_ga;
   bit              sb_on;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_grant = 0;
      m_owner = 0;
      m_cnt   = 0;
      m_last  = NREQ - 1;
      for (int i = 0; i < NREQ; i++) waitg[i] = 0;
   endtask

   task automatic clear_logs();
      wr_cyc.delete();
      wr_dat.delete();
      wr_id.delete();
      glog.delete();
   endtask

   task automatic adv();
      for (int i = 0; i < NREQ; i++) if (acc_mask[i]) dat[i]++;
   endtask

   // One clock: drive inputs, check outputs at negedge, then advance the model.
   task automatic step();
      logic [NREQ-1:0] er;
      logic            ewe;
      logic [DW-1:0]   ed;
      bit              found;
      int              g;
      bus.req_valid = vld;
      bus.fifo_full = full;
      for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = dat[i];
      @(negedge clk);
      er  = '0;
      ewe = 1'b0;
      ed  = '0;
      if (m_grant != 0) begin
         ed = dat[m_owner];
         if (!reset && !full) er[m_owner] = 1'b1;
         ewe = !reset && !full && vld[m_owner];
      end
      chk("req_ready",    bus.req_ready,    er);
      chk("fifo_write_e", bus.fifo_write_e, ewe);
      chk("fifo_data_in", bus.fifo_data_in, ed);
      chk("grant_active", bus.grant_active, m_grant);
      chk("grant_id",     bus.grant_id,     m_owner);
      chk("write_while_full", bus.fifo_write_e & bus.fifo_full, 0);
      if (bus.grant_active === 1'b1 && prev_ga !== 1'b1) begin
         g = int'(bus.grant_id);
         glog.push_back(g);
         for (int i = 0; i < NREQ; i++) begin
            if (i == g || !vld_prev[i]) waitg[i] = 0;
            else waitg[i]++;
            chk("fair_wait", waitg[i] <= NREQ - 1, 1);
         end
      end
      prev_ga = bus.grant_active;
      if (bus.fifo_write_e === 1'b1) begin
         wr_cyc.push_back(cyc);
         wr_dat.push_back(int'(bus.fifo_data_in));
         wr_id.push_back(int'(bus.grant_id));
         if (sb_on) begin
            chk("sb_order", bus.fifo_data_in, sb_next[bus.grant_id]);
            sb_next[bus.grant_id]++;
         end
      end
      acc_mask = ewe ? (1 << m_owner) : 0;
      if (ewe) model_acc++;
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else if (m_grant == 0) begin
         found = 0;
         for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (!found && vld[idx]) begin
               found   = 1;
               m_grant = 1;
               m_owner = idx;
               m_cnt   = 0;
            end
         end
      end else if (!vld[m_owner]) begin
         m_grant = 0;
         m_last  = m_owner;
      end else if (!full) begin
         m_cnt++;
         if (m_cnt == MAX_BURST) begin
            m_grant = 0;
            m_last  = m_owner;
         end
      end
      vld_prev = vld;
      cyc++;
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      clear_logs();
   endtask

   initial begin
      vld      = '0;
      vld_prev = '0;
      full     = 1'b0;
      sb_on    = 1'b0;
      prev_ga  = 1'b0;
      model_acc = 0;
      for (int i = 0; i < NREQ; i++) begin
         dat[i]     = '0;
         sb_next[i] = '0;
      end
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      step();
      step();
      reset = 1'b0;
      clear_logs();

      // Single requester: two bursts of four with one bubble.
      dat[0] = 8'h10;
      vld    = 4'b0001;
      for (int t = 0; t < 30 && wr_dat.size() < 8; t++) begin
         step();
         adv();
         if (dat[0] == 8'h18) vld = '0;
      end
      chk("t1_count", wr_dat.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk("t1_data",    wr_dat[i], 8'h10 + i);
         chk("t1_id",      wr_id[i], 0);
         chk("t1_spacing", wr_cyc[i] - wr_cyc[0], i + ((i >= 4) ? 1 : 0));
      end

      // All four saturated: order 0,1,2,3,0 and 16 writes in 20 cycles.
      vld = '0;
      pulse_reset();
      for (int i = 0; i < NREQ; i++) dat[i] = 8'(i * 32);
      vld = '1;
      repeat (22) begin
         step();
         adv();
      end
      chk("t2_count", wr_dat.size(), 17);
      chk("t2_span",  wr_cyc[15] - wr_cyc[0], 18);
      chk("t2_grants", glog.size(), 5);
      for (int g = 0; g < 5; g++) chk("t2_order", glog[g], g % 4);
      for (int i = 0; i < 16; i++) begin
         chk("t2_id",   wr_id[i], i / 4);
         chk("t2_data", wr_dat[i], (i / 4) * 32 + (i % 4));
      end

      // Owner 2 stalled by full for three cycles mid-burst.
      vld = '0;
      pulse_reset();
      dat[2] = 8'h40;
      vld    = 4'b0100;
      for (int t = 0; t < 10 && wr_dat.size() < 2; t++) begin
         step();
         adv();
      end
      full = 1'b1;
      repeat (3) begin
         step();
         adv();
         chk("t3_stall_ready", bus.req_ready, 0);
      end
      full = 1'b0;
      for (int t = 0; t < 10 && dat[2] != 8'h44; t++) begin
         step();
         adv();
      end
      vld = '0;
      repeat (3) step();
      chk("t3_count", wr_dat.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t3_data", wr_dat[i], 8'h40 + i);
         chk("t3_id",   wr_id[i], 2);
      end
      chk("t3_stall_gap", wr_cyc[2] - wr_cyc[1], 4);

      // Requester 1 drops valid after one beat while 3 waits.
      vld = '0;
      pulse_reset();
      dat[1] = 8'h50;
      dat[3] = 8'h70;
      vld    = 4'b1010;
      for (int t = 0; t < 10 && wr_dat.size() < 1; t++) begin
         step();
         adv();
      end
      vld = 4'b1000;
      step();
      adv();
      vld = 4'b1010;
      repeat (8) begin
         step();
         adv();
      end
      chk("t4_first_grant",  glog[0], 1);
      chk("t4_second_grant", glog[1], 3);
      chk("t4_second_id",    wr_id[1], 3);
      chk("t4_second_data",  wr_dat[1], 8'h70);
      chk("t4_bubble",       wr_cyc[1] - wr_cyc[0], 3);

      // Reset during owner 1's third beat.
      vld = '0;
      pulse_reset();
      dat[1] = 8'h60;
      vld    = 4'b0010;
      for (int t = 0; t < 10 && wr_dat.size() < 2; t++) begin
         step();
         adv();
      end
      reset = 1'b1;
      step();
      chk("t5_no_write_in_reset", wr_dat.size(), 2);
      chk("t5_rst_gact", bus.grant_active, 0);
      chk("t5_rst_gid",  bus.grant_id, 0);
      chk("t5_rst_din",  bus.fifo_data_in, 0);
      chk("t5_rst_rdy",  bus.req_ready, 0);
      reset  = 1'b0;
      dat[2] = 8'h80;
      vld    = 4'b0110;
      repeat (4) begin
         step();
         adv();
      end
      chk("t5_regrant", glog[glog.size() - 1], 1);
      chk("t5_third_beat", wr_dat[2], 8'h62);

      // Random traffic with per-requester ordering scoreboard.
      vld  = '0;
      full = 1'b0;
      pulse_reset();
      for (int i = 0; i < NREQ; i++) begin
         dat[i]     = 8'(i * 64);
         sb_next[i] = dat[i];
      end
      model_acc = 0;
      sb_on     = 1'b1;
      for (int t = 0; t < 10000; t++) begin
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i]) begin
               dat[i]++;
               if ($urandom_range(1, 0) == 0) vld[i] = 1'b0;
            end else if (!vld[i] && $urandom_range(9, 0) < 4) begin
               vld[i] = 1'b1;
            end
         end
         full = ($urandom_range(3, 0) == 0);
      end
      sb_on = 1'b0;
      chk("t6_total_writes", wr_dat.size(), model_acc);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
